snn_timestep_scheduler: RTL and testbench

//   Sequences a layer of spiking neurons through an inference run of N_TIMESTEPS steps.
//   - Arbitrates signed spike events from N_REQ upstream requesters onto one shared

---
 rtl/snn_sched_pkg.sv | 16 +
 rtl/snn_timestep_scheduler_arb.sv | 45 ++++
 rtl/snn_timestep_scheduler.sv | 147 ++++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_sched_pkg.sv
// Shared types for the SNN timestep scheduler.
// FSM state encoding and spike-sign constants.
package snn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    FIRE,
    DONE
  } sched_state_e;

  localparam logic SPIKE_POS = 1'b0;
  localparam logic SPIKE_NEG = 1'b1;

endpackage

// File: rtl/snn_timestep_scheduler_arb.sv
// rr_arbiter: round-robin grant over N requesters.
// Ports: req, advance -> one-hot grant, grant_idx, ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic [IW-1:0] ptr
);

  int   k;
  logic found;

  // first requester at or after ptr, wrapping
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr) + off;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      if (grant_idx == IW'(N - 1)) ptr <= '0;
      else                         ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Timestep scheduler: event arbitration, clear/fire/done sequencing.
// Optional acc_ready backpressure via SCHED_BACKPRESSURE_EN.
module snn_timestep_scheduler
  import snn_sched_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int N_TIMESTEPS = 16,
  parameter  int FIRE_CYCLES = 2,
  localparam int IDX_W       = $clog2(N_REQ),
  localparam int TS_W        = $clog2(N_TIMESTEPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_neg,
  output logic [N_REQ-1:0] req_ready,
  input  logic             step_end,
`ifdef SCHED_BACKPRESSURE_EN
  input  logic             acc_ready,
`endif
  output logic             acc_valid,
  output logic [IDX_W-1:0] acc_idx,
  output logic             acc_neg,
  output logic             clear_en,
  output logic             fire_en,
  output logic [TS_W-1:0]  timestep,
  output logic             busy,
  output logic             done
);

  localparam int FC_W = $clog2(FIRE_CYCLES + 1);

  sched_state_e     state, state_nx;
  logic             step_seen;
  logic             step_hit;
  logic [FC_W-1:0]  fire_cnt;
  logic             fire_last;
  logic             last_step;
  logic             stall;
  logic             xfer;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] rr_ptr;

`ifdef SCHED_BACKPRESSURE_EN
  assign stall = acc_valid & ~acc_ready;
`else
  assign stall = 1'b0;
`endif

  assign arb_req   = (state == ACCUM && !stall) ? req_valid : '0;
  assign req_ready = grant;
  assign xfer      = |grant;
  assign step_hit  = step_seen | step_end;
  assign fire_last = fire_cnt == FC_W'(FIRE_CYCLES - 1);
  assign last_step = timestep == TS_W'(N_TIMESTEPS - 1);

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDX_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr       (rr_ptr)
  );

  always_comb begin
    state_nx = state;
    clear_en = 1'b0;
    fire_en  = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = CLEAR;
      end
      CLEAR: begin
        clear_en = 1'b1;
        state_nx = ACCUM;
      end
      ACCUM: begin
        // no pending events and no unaccepted accumulate left
        if (step_hit && req_valid == '0 && !stall)
          state_nx = FIRE;
      end
      FIRE: begin
        fire_en = 1'b1;
        if (fire_last) state_nx = last_step ? DONE : ACCUM;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_seen <= 1'b0;
      fire_cnt  <= '0;
      timestep  <= '0;
    end else begin
      state <= state_nx;
      if (state == ACCUM && state_nx == ACCUM) step_seen <= step_hit;
      else                                     step_seen <= 1'b0;
      if (state == FIRE && !fire_last) fire_cnt <= fire_cnt + 1'b1;
      else                             fire_cnt <= '0;
      if (state == FIRE && fire_last && !last_step)
        timestep <= timestep + 1'b1;
      else if (state == DONE)
        timestep <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid <= 1'b0;
      acc_idx   <= '0;
      acc_neg   <= SPIKE_POS;
    end else begin
      if (xfer) begin
        acc_valid <= 1'b1;
        acc_idx   <= grant_idx;
        acc_neg   <= req_neg[grant_idx];
      end
`ifdef SCHED_BACKPRESSURE_EN
      else if (acc_ready) begin
        acc_valid <= 1'b0;
      end
`else
      else begin
        acc_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Directed bench for snn_timestep_scheduler.
// N_TIMESTEPS=3, N_REQ=4, FIRE_CYCLES=2.
module tb_snn_timestep_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] req_valid;
  logic [3:0] req_neg;
  logic [3:0] req_ready;
  logic       step_end;
`ifdef SCHED_BACKPRESSURE_EN
  logic       acc_ready;
`endif
  logic       acc_valid;
  logic [1:0] acc_idx;
  logic       acc_neg;
  logic       clear_en;
  logic       fire_en;
  logic [1:0] timestep;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  snn_timestep_scheduler #(
    .N_REQ       (4),
    .N_TIMESTEPS (3),
    .FIRE_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .req_valid (req_valid),
    .req_neg   (req_neg),
    .req_ready (req_ready),
    .step_end  (step_end),
`ifdef SCHED_BACKPRESSURE_EN
    .acc_ready (acc_ready),
`endif
    .acc_valid (acc_valid),
    .acc_idx   (acc_idx),
    .acc_neg   (acc_neg),
    .clear_en  (clear_en),
    .fire_en   (fire_en),
    .timestep  (timestep),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 0);
    chk({tag, ".acc_valid"}, 32'(acc_valid), 0);
    chk({tag, ".acc_idx"},   32'(acc_idx),   0);
    chk({tag, ".acc_neg"},   32'(acc_neg),   0);
    chk({tag, ".clear_en"},  32'(clear_en),  0);
    chk({tag, ".fire_en"},   32'(fire_en),   0);
    chk({tag, ".timestep"},  32'(timestep),  0);
    chk({tag, ".busy"},      32'(busy),      0);
    chk({tag, ".done"},      32'(done),      0);
  endtask

  // start from IDLE, check CLEAR then land in ACCUM
  task automatic begin_run(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    chk({tag, ".clear_en"}, 32'(clear_en), 1);
    chk({tag, ".busy"},     32'(busy),     1);
    chk({tag, ".ts0"},      32'(timestep), 0);
    tick();
    chk({tag, ".clear_off"}, 32'(clear_en), 0);
    chk({tag, ".acc_busy"},  32'(busy),     1);
  endtask

  // step_end with nothing pending, then two fire cycles
  task automatic do_step(input string tag, input int s);
    step_end = 1'b1;
    tick();
    step_end = 1'b0;
    settle();
    chk({tag, ".fire0"},  32'(fire_en),   1);
    chk({tag, ".ts"},     32'(timestep),  s);
    chk({tag, ".noacc0"}, 32'(acc_valid), 0);
    tick();
    chk({tag, ".fire1"},  32'(fire_en),   1);
    chk({tag, ".ts1"},    32'(timestep),  s);
    tick();
    chk({tag, ".fire_off"}, 32'(fire_en), 0);
    if (s == 2) begin
      chk({tag, ".done"}, 32'(done), 1);
      tick();
      chk({tag, ".done_off"}, 32'(done),     0);
      chk({tag, ".idle"},     32'(busy),     0);
      chk({tag, ".ts_rst"},   32'(timestep), 0);
    end else begin
      chk({tag, ".no_done"}, 32'(done),     0);
      chk({tag, ".ts_inc"},  32'(timestep), s + 1);
    end
  endtask

  initial begin
    int cnt [4];
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    req_valid = '0;
    req_neg   = '0;
    step_end  = 1'b0;
`ifdef SCHED_BACKPRESSURE_EN
    acc_ready = 1'b1;
`endif
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_zero("post_reset");

    // 1: empty run, 3 steps
    begin_run("t1");
    for (int s = 0; s < 3; s++) do_step("t1", s);

    // 2: four requesters, two events each
    begin_run("t2");
    req_neg = 4'b0101;
    for (int i = 0; i < 4; i++) cnt[i] = 2;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) req_valid[i] = cnt[i] > 0;
      settle();
      chk("t2.ready", 32'(req_ready), 32'(1) << (k % 4));
      tick();
      cnt[k % 4]--;
      chk("t2.acc_valid", 32'(acc_valid), 1);
      chk("t2.acc_idx",   32'(acc_idx),   k % 4);
      chk("t2.acc_neg",   32'(acc_neg),   32'(req_neg[k % 4]));
    end
    req_valid = '0;
    tick();
    chk("t2.acc_idle", 32'(acc_valid), 0);

    // 3: drain on step_end with req 1 and 3 pending
    req_neg   = 4'b1000;
    req_valid = 4'b1010;
    step_end  = 1'b1;
    settle();
    chk("t3.ready1", 32'(req_ready), 32'b0010);
    tick();
    step_end  = 1'b0;
    req_valid = 4'b1000;
    settle();
    chk("t3.acc_v1",  32'(acc_valid), 1);
    chk("t3.idx1",    32'(acc_idx),   1);
    chk("t3.neg1",    32'(acc_neg),   0);
    chk("t3.nofire1", 32'(fire_en),   0);
    chk("t3.ready3",  32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    settle();
    chk("t3.acc_v3",  32'(acc_valid), 1);
    chk("t3.idx3",    32'(acc_idx),   3);
    chk("t3.neg3",    32'(acc_neg),   1);
    chk("t3.nofire3", 32'(fire_en),   0);
    tick();
    chk("t3.fire",    32'(fire_en),   1);
    chk("t3.acc_off", 32'(acc_valid), 0);
    tick();
    tick();
    chk("t3.ts1", 32'(timestep), 1);

    // 4: grant 3, then 0 and 3 valid -> 0
    req_valid = 4'b1000;
    settle();
    chk("t4.g3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b1001;
    settle();
    chk("t4.wrap", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b1000;
    settle();
    chk("t4.g3b", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;

    // 5: reset during FIRE of step 1
    step_end = 1'b1;
    tick();
    step_end = 1'b0;
    settle();
    chk("t5.fire", 32'(fire_en),  1);
    chk("t5.ts",   32'(timestep), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("t5.async");
    repeat (2) tick();
    chk("t5.no_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();
    chk_zero("t5.release");
    begin_run("t5.rerun");

`ifdef SCHED_BACKPRESSURE_EN
    // 6: hold acc_* while acc_ready is low
    req_neg   = 4'b0010;
    req_valid = 4'b0011;
    settle();
    chk("t6.g0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    acc_ready = 1'b0;
    settle();
    chk("t6.stall_rdy", 32'(req_ready), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6.hold_v",   32'(acc_valid), 1);
      chk("t6.hold_idx", 32'(acc_idx),   0);
      chk("t6.hold_neg", 32'(acc_neg),   0);
      chk("t6.hold_rdy", 32'(req_ready), 0);
    end
    acc_ready = 1'b1;
    settle();
    chk("t6.resume", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    settle();
    chk("t6.v1",   32'(acc_valid), 1);
    chk("t6.idx1", 32'(acc_idx),   1);
    chk("t6.neg1", 32'(acc_neg),   1);
    tick();
    chk("t6.v_off", 32'(acc_valid), 0);
`endif

    for (int s = 0; s < 3; s++) do_step("t5.run", s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
